alu_arb: RTL and testbench

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb.sv | 198 +++++++++++++++++++
 tb/tb_alu_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arb.sv
// Two-requester front end that time-shares one combinational ALU.
// Round-robin grant in IDLE, one EXEC cycle, result held in RESP until taken.

module alu #(
  parameter int DATA_LEN = 32
) (
  input  logic [DATA_LEN-1:0] i_a,
  input  logic [DATA_LEN-1:0] i_b,
  input  logic [2:0]          i_ctl,
  output logic [DATA_LEN-1:0] o_res,
  output logic [3:0]          o_nzcv
);

  logic                w_sub;
  logic [DATA_LEN-1:0] w_b_eff;
  logic [DATA_LEN:0]   w_sum;
  logic                w_ovf;
  logic                w_lt;
  logic                w_eq;
  logic                w_c;
  logic                w_v;

  // Subtraction is a + ~b + 1, so C is "no borrow" on 001.
  assign w_sub   = (i_ctl == 3'b001);
  assign w_b_eff = w_sub ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{DATA_LEN{1'b0}}, w_sub};
  assign w_ovf   = (i_a[DATA_LEN-1] == w_b_eff[DATA_LEN-1]) &&
                   (w_sum[DATA_LEN-1] != i_a[DATA_LEN-1]);
  assign w_lt    = ($signed(i_a) < $signed(i_b));
  assign w_eq    = (i_a == i_b);

  always_comb begin
    o_res = {DATA_LEN{1'b0}};
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_ctl)
      3'b000, 3'b001: begin
        o_res = w_sum[DATA_LEN-1:0];
        w_c   = w_sum[DATA_LEN];
        w_v   = w_ovf;
      end
      3'b010:  o_res = ~i_a;
      3'b011:  o_res = i_a & i_b;
      3'b100:  o_res = i_a | i_b;
      3'b101:  o_res = i_a ^ i_b;
      3'b110:  o_res = {{(DATA_LEN-1){1'b0}}, w_lt};
      3'b111:  o_res = {{(DATA_LEN-1){1'b0}}, w_eq};
      default: o_res = {DATA_LEN{1'b0}};
    endcase
  end

  assign o_nzcv = {o_res[DATA_LEN-1], (o_res == {DATA_LEN{1'b0}}), w_c, w_v};

endmodule

module alu_arb #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_LEN-1:0] req0_a,
  input  logic [DATA_LEN-1:0] req0_b,
  input  logic [2:0]          req0_ctl,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_LEN-1:0] req1_a,
  input  logic [DATA_LEN-1:0] req1_b,
  input  logic [2:0]          req1_ctl,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_LEN-1:0] rsp_res,
  output logic [3:0]          rsp_nzcv,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_any;
  logic                w_grant_id;
  logic                w_accept;
  logic                r_last;
  logic [DATA_LEN-1:0] r_a;
  logic [DATA_LEN-1:0] r_b;
  logic [2:0]          r_ctl;
  logic                r_id;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [DATA_LEN-1:0] r_rsp_res;
  logic [3:0]          r_rsp_nzcv;
  logic                r_busy;
  logic [DATA_LEN-1:0] w_alu_res;
  logic [3:0]          w_alu_nzcv;

  alu #(.DATA_LEN(DATA_LEN)) u_alu (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_ctl  (r_ctl),
    .o_res  (w_alu_res),
    .o_nzcv (w_alu_nzcv)
  );

  assign w_any    = req0_valid | req1_valid;
  assign w_accept = (r_state == IDLE) && w_any;

  // On a tie, r_last=1 means requester 1 won last time, so requester 0 goes next.
  always_comb begin
    if (req0_valid && req1_valid) begin
      w_grant_id = ~r_last;
    end else if (req1_valid) begin
      w_grant_id = 1'b1;
    end else begin
      w_grant_id = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) w_next = EXEC;
        else       w_next = IDLE;
      end
      EXEC: w_next = RESP;
      RESP: begin
        if (rsp_ready) w_next = IDLE;
        else           w_next = RESP;
      end
      default: w_next = IDLE;
    endcase
  end

  // Ready is gated by rst_n so it drops immediately with reset, not at the next edge.
  always_comb begin
    if (rst_n && w_accept) begin
      req0_ready = ~w_grant_id;
      req1_ready = w_grant_id;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= 1'b1;
      r_a         <= {DATA_LEN{1'b0}};
      r_b         <= {DATA_LEN{1'b0}};
      r_ctl       <= 3'b000;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_res   <= {DATA_LEN{1'b0}};
      r_rsp_nzcv  <= 4'b0000;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_next != IDLE);
      if (w_accept) begin
        r_last <= w_grant_id;
        r_id   <= w_grant_id;
        r_a    <= w_grant_id ? req1_a   : req0_a;
        r_b    <= w_grant_id ? req1_b   : req0_b;
        r_ctl  <= w_grant_id ? req1_ctl : req0_ctl;
      end
      if (r_state == EXEC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_res   <= w_alu_res;
        r_rsp_nzcv  <= w_alu_nzcv;
      end else if ((r_state == RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_res   = r_rsp_res;
  assign rsp_nzcv  = r_rsp_nzcv;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb: ALU ops, latency, round-robin, backpressure, reset abort.

module tb_alu_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctl, req1_ctl;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_res;
  logic [3:0]  rsp_nzcv;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arb #(.DATA_LEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctl   (req0_ctl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctl   (req1_ctl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_res    (rsp_res),
    .rsp_nzcv   (rsp_nzcv),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input bit id, input bit v, input logic [2:0] ctl,
                         input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      req1_valid = v; req1_ctl = ctl; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_ctl = ctl; req0_a = a; req0_b = b;
    end
  endtask

  // Call at posedge+1 with the DUT idle and rsp_ready=1; returns at posedge+1, idle again.
  task automatic run_op(input string tag, input bit id, input logic [2:0] ctl,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] enz);
    set_req(id, 1'b1, ctl, a, b);
    #1;
    check_val({tag, ".rdy_own"}, id ? req1_ready : req0_ready, 1'b1);
    check_val({tag, ".rdy_oth"}, id ? req0_ready : req1_ready, 1'b0);
    @(posedge clk); #1;
    set_req(id, 1'b0, ~ctl, ~a, b ^ 32'hA5A5_5A5A);
    check_val({tag, ".exec_busy"}, busy, 1'b1);
    check_val({tag, ".exec_vld"}, rsp_valid, 1'b0);
    @(posedge clk); #1;
    check_val({tag, ".vld"}, rsp_valid, 1'b1);
    check_val({tag, ".res"}, rsp_res, er);
    check_val({tag, ".nzcv"}, rsp_nzcv, enz);
    check_val({tag, ".id"}, rsp_id, id);
    @(posedge clk); #1;
    check_val({tag, ".done_vld"}, rsp_valid, 1'b0);
    check_val({tag, ".done_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 3'b000, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
    #2;
    check_val("rst.vld",  rsp_valid, 1'b0);
    check_val("rst.res",  rsp_res, 32'h0);
    check_val("rst.nzcv", rsp_nzcv, 4'h0);
    check_val("rst.id",   rsp_id, 1'b0);
    check_val("rst.busy", busy, 1'b0);
    check_val("rst.rdy0", req0_ready, 1'b0);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_wrap", 1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110);
    run_op("add_ovf",  1'b0, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
    run_op("sub_zero", 1'b1, 3'b001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110);
    run_op("not",      1'b0, 3'b010, 32'h0F0F_0F0F, 32'h1234_5678, 32'hF0F0_F0F0, 4'b1000);
    run_op("and",      1'b1, 3'b011, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 4'b0000);
    run_op("or",       1'b0, 3'b100, 32'hF000_0000, 32'h0000_0001, 32'hF000_0001, 4'b1000);
    run_op("xor",      1'b1, 3'b101, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 4'b0100);
    run_op("slt_t",    1'b0, 3'b110, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0001, 4'b0000);
    run_op("slt_f",    1'b1, 3'b110, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0000, 4'b0100);
    run_op("eq_f",     1'b0, 3'b111, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 4'b0100);
    run_op("sub_ovf",  1'b1, 3'b001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1001);

    // Reset during EXEC aborts the operation and clears the held response.
    set_req(1'b0, 1'b1, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
    #1;
    check_val("abort.rdy0", req0_ready, 1'b1);
    @(posedge clk); #1;
    check_val("abort.busy_exec", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("abort.vld",  rsp_valid, 1'b0);
    check_val("abort.res",  rsp_res, 32'h0);
    check_val("abort.nzcv", rsp_nzcv, 4'h0);
    check_val("abort.id",   rsp_id, 1'b0);
    check_val("abort.busy", busy, 1'b0);
    check_val("abort.rdy0", req0_ready, 1'b0);
    @(posedge clk); #1;
    check_val("abort.vld_hold", rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters valid: grants alternate 0,1,0,1, one response per 3 cycles.
    set_req(1'b0, 1'b1, 3'b111, 32'h5, 32'h5);
    set_req(1'b1, 1'b1, 3'b111, 32'h5, 32'h5);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("rr.rdy0", req0_ready, (i % 2) == 0);
      check_val("rr.rdy1", req1_ready, (i % 2) == 1);
      @(posedge clk); #1;
      check_val("rr.exec_vld", rsp_valid, 1'b0);
      @(posedge clk); #1;
      check_val("rr.vld",  rsp_valid, 1'b1);
      check_val("rr.res",  rsp_res, 32'h1);
      check_val("rr.nzcv", rsp_nzcv, 4'b0000);
      check_val("rr.id",   rsp_id, (i % 2) == 1);
      @(posedge clk); #1;
      check_val("rr.idle_vld", rsp_valid, 1'b0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure: response held while req1 waits.
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 3'b100, 32'hF000_0000, 32'h0000_0001);
    #1;
    check_val("bp.rdy0", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    set_req(1'b1, 1'b1, 3'b011, 32'hFF00_FF00, 32'h0F0F_0F0F);
    check_val("bp.exec_rdy1", req1_ready, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check_val("bp.vld",  rsp_valid, 1'b1);
      check_val("bp.res",  rsp_res, 32'hF000_0001);
      check_val("bp.nzcv", rsp_nzcv, 4'b1000);
      check_val("bp.id",   rsp_id, 1'b0);
      check_val("bp.rdy1", req1_ready, 1'b0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    check_val("bp.hs_rdy1", req1_ready, 1'b0);
    @(posedge clk); #1;
    check_val("bp.idle_vld",  rsp_valid, 1'b0);
    check_val("bp.idle_rdy1", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    check_val("bp.r1_busy", busy, 1'b1);
    @(posedge clk); #1;
    check_val("bp.r1_vld",  rsp_valid, 1'b1);
    check_val("bp.r1_res",  rsp_res, 32'h0F00_0F00);
    check_val("bp.r1_nzcv", rsp_nzcv, 4'b0000);
    check_val("bp.r1_id",   rsp_id, 1'b1);
    @(posedge clk); #1;
    check_val("bp.r1_done", rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
